// File: rtl/sap_ram.sv
// SAP-1 read/write program/data memory: tri-state asynchronous read, synchronous
// bus writes, a streaming valid/ready program loader and a zero-fill clear sweep.
module sap_ram #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_low_oe,
  input  logic              we,
  input  logic [DATA_W-1:0] bus_in,
  output tri   [DATA_W-1:0] data,
  input  logic              mode_prog,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_full,
  input  logic              clear_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PROG  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_full;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_xfer;
  logic              w_wen;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (clear_req)      w_next = CLEAR;
        else if (mode_prog) w_next = PROG;
      end
      PROG: begin
        if (!mode_prog) w_next = RUN;
      end
      CLEAR: begin
        if (r_ptr == LAST) w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end

  assign w_xfer     = (r_state == PROG) && prog_valid && !r_full;
  assign w_busy     = (r_state == CLEAR);
  assign busy       = w_busy;
  assign prog_ready = (r_state == PROG) && !r_full;
  assign prog_full  = r_full;
  assign prog_addr  = w_busy ? '0 : r_ptr;
  assign data       = ((r_state == RUN) && !mem_low_oe) ? r_mem[addr] : 'z;

  // One shared write port; the active state picks its address and data source.
  always_comb begin
    w_wen   = 1'b0;
    w_waddr = addr;
    w_wdata = bus_in;
    case (r_state)
      RUN: w_wen = we;
      PROG: begin
        w_wen   = w_xfer;
        w_waddr = r_ptr;
        w_wdata = prog_data;
      end
      CLEAR: begin
        w_wen   = 1'b1;
        w_waddr = r_ptr;
        w_wdata = '0;
      end
      default: w_wen = 1'b0;
    endcase
    if (rst) w_wen = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wen) r_mem[w_waddr] <= w_wdata;
  end

  // The pointer is shared: sweep index in CLEAR, load index in PROG.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: r_ptr <= r_ptr + ADDR_W'(1);
        RUN: begin
          if (clear_req) begin
            r_ptr <= '0;
          end else if (mode_prog) begin
            r_ptr  <= '0;
            r_full <= 1'b0;
          end
        end
        PROG: begin
          if (w_xfer) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (r_ptr == LAST) r_full <= 1'b1;
          end
        end
        default: r_ptr <= '0;
      endcase
    end
  end

endmodule
